// File: rtl/freq_gate_counter.sv
// -----------------------------------------------------------------------------
// freq_gate_counter
//
// Gated frequency counter. Counts rising edges of an asynchronous input over a
// fixed window of GATE_CYCLES reference clocks and publishes the count once per
// window. Intended for checking a PLL output against its reference clock.
//
// Sequence while the synchronised lock is high:
//   IDLE -> GATE (GATE_CYCLES cycles) -> DONE (1 cycle) -> GATE -> DONE ...
// Losing lock during GATE abandons the window without publishing a result.
//
// Parameters
//   GATE_CYCLES  window length in refclk cycles, 2 .. 2^32-1 (default 50000)
//   CNT_W        width of the published edge count (default 24)
//
// Ports
//   refclk       in   block clock (reference domain)
//   rst          in   synchronous active-high reset
//   meas_in      in   signal under measurement, asynchronous to refclk
//   pll_locked   in   PLL lock indication, asynchronous to refclk
//   freq_count   out  [CNT_W] rising edges counted in the last completed window
//   count_valid  out  one-cycle pulse (the DONE cycle) marking a new freq_count
//   overflow     out  last completed window saw more than 2^CNT_W-1 edges
//   busy         out  high while in GATE or DONE
//
// Build option
//   FREQ_GATE_OVF_EN  defined:   edge counter saturates and overflow is reported
//                     undefined: edge counter wraps, overflow is tied low
// -----------------------------------------------------------------------------
module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = 24
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             meas_in,
    input  logic             pll_locked,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;

    // Synchronisers: m1/m2 resynchronise meas_in, m3 is the edge history flop.
    logic             m1_q, m2_q, m3_q;
    logic             lk1_q, lk_s_q;

    logic [31:0]      gate_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] freq_count_q;
    logic             count_valid_q;
    logic             busy_q;

    logic             edge_det;
    logic             gate_last;
    logic             count_en;

`ifdef FREQ_GATE_OVF_EN
    logic             ovf_flag_q, ovf_flag_d;
    logic             overflow_q;
`endif

    assign edge_det  = m2_q & ~m3_q;
    assign gate_last = (gate_cnt_q == GATE_LAST);
    // Counters advance only in a GATE cycle that neither aborts nor closes the
    // window; every other cycle (IDLE, DONE, abort, window close) clears them.
    assign count_en  = (state_q == GATE) && lk_s_q && !gate_last;

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the value from before the edge, giving a true 2-flop delay.
    always_ff @(posedge refclk) begin
        if (rst) begin
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
            m3_q   <= 1'b0;
            lk1_q  <= 1'b0;
            lk_s_q <= 1'b0;
        end else begin
            m1_q   <= meas_in;
            m2_q   <= m1_q;
            m3_q   <= m2_q;
            lk1_q  <= pll_locked;
            lk_s_q <= lk1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Next edge count, including the current cycle's edge
    // -------------------------------------------------------------------------
`ifdef FREQ_GATE_OVF_EN
    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        ovf_flag_d = ovf_flag_q;
        if (edge_det) begin
            if (&edge_cnt_q) begin
                ovf_flag_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1'b1);
            end
        end
    end
`else
    always_comb begin
        edge_cnt_d = edge_cnt_q + CNT_W'(edge_det);
    end
`endif

    // -------------------------------------------------------------------------
    // Gate and edge counters
    // -------------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst || !count_en) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
`ifdef FREQ_GATE_OVF_EN
            ovf_flag_q <= 1'b0;
`endif
        end else begin
            gate_cnt_q <= gate_cnt_q + 32'd1;
            edge_cnt_q <= edge_cnt_d;
`ifdef FREQ_GATE_OVF_EN
            ovf_flag_q <= ovf_flag_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q       <= IDLE;
            freq_count_q  <= '0;
            count_valid_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef FREQ_GATE_OVF_EN
            overflow_q    <= 1'b0;
`endif
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lk_s_q) begin
                        state_q <= GATE;
                        busy_q  <= 1'b1;
                    end
                end
                GATE: begin
                    if (!lk_s_q) begin
                        // Abort: partial count is dropped, published result kept.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (gate_last) begin
                        // Result and pulse become visible together in DONE.
                        state_q       <= DONE;
                        freq_count_q  <= edge_cnt_d;
                        count_valid_q <= 1'b1;
`ifdef FREQ_GATE_OVF_EN
                        overflow_q    <= ovf_flag_d;
`endif
                    end
                end
                DONE: begin
                    if (lk_s_q) begin
                        state_q <= GATE;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign freq_count  = freq_count_q;
    assign count_valid = count_valid_q;
    assign busy        = busy_q;
`ifdef FREQ_GATE_OVF_EN
    assign overflow    = overflow_q;
`else
    assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// -----------------------------------------------------------------------------
// tb_freq_gate_counter
//
// Scoreboard bench for freq_gate_counter (GATE_CYCLES=1000, CNT_W=8).
// The stimulus process plans each gate window's meas_in waveform ahead of time
// in hist[], derives the expected result from that waveform (rising edges seen
// two refclk cycles late through the synchroniser, counted over the window's
// 1000 cycles), and queues it with the cycle at which the result must appear.
// A monitor pops the queue on every count_valid pulse.
// -----------------------------------------------------------------------------
module tb_freq_gate_counter;

    localparam int GATE   = 1000;
    localparam int CW     = 8;
    localparam int MAXV   = (1 << CW) - 1;
    localparam int PERIOD = GATE + 1;
    localparam int HMAX   = 16384;

    logic          refclk = 1'b0;
    logic          rst;
    logic          meas_in;
    logic          pll_locked;
    logic [CW-1:0] freq_count;
    logic          count_valid;
    logic          overflow;
    logic          busy;

    typedef struct {
        int cnt;
        int ovf;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   hist [HMAX];   // meas_in value sampled at posedge i
    int   plan_q[$];
    int   cyc;           // index of the most recent posedge
    int   n_checks;
    int   n_errs;
    int   last_cnt;
    int   s;
    int   t;

    freq_gate_counter #(
        .GATE_CYCLES(GATE),
        .CNT_W      (CW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .meas_in    (meas_in),
        .pll_locked (pll_locked),
        .freq_count (freq_count),
        .count_valid(count_valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input longint actual, input longint required);
        n_checks++;
        if (actual != required) begin
            n_errs++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, actual, required);
        end
    endtask

    // Drive the value planned for the next posedge, then advance one cycle.
    task automatic tick();
        meas_in = hist[cyc + 1];
        @(posedge refclk);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // p == 0: held high; otherwise period p with random duty and phase.
    task automatic fill(input int from, input int to, input int p);
        int hi;
        int ph;
        hi = 0;
        ph = 0;
        if (p > 0) begin
            hi = int'($urandom_range(p - 1, 1));
            ph = int'($urandom_range(p - 1, 0));
        end
        for (int i = from; i <= to; i++) begin
            if (i >= 0 && i < HMAX) hist[i] = (p == 0) ? 1'b1 : (((i + ph) % p) < hi);
        end
    endtask

    // Window starting when busy rises after posedge gs: counting posedges are
    // gs+1 .. gs+GATE, each counting a rise sampled two posedges earlier.
    task automatic plan_gate(input int gs, input int p, input bit expect_it);
        int   n;
        exp_t e;
        fill(gs - 2, gs + GATE - 2, p);
        if (expect_it) begin
            n = 0;
            for (int c = gs + 1; c <= gs + GATE; c++) begin
                if (hist[c - 2] && !hist[c - 3]) n++;
            end
`ifdef FREQ_GATE_OVF_EN
            e.cnt = (n > MAXV) ? MAXV : n;
            e.ovf = (n > MAXV) ? 1 : 0;
`else
            e.cnt = n % (MAXV + 1);
            e.ovf = 0;
`endif
            e.cyc = gs + GATE;
            exp_q.push_back(e);
            last_cnt = e.cnt;
        end
    endtask

    // Back-to-back windows with lock held; gs is the already-planned window.
    task automatic run_chain(inout int gs);
        while (plan_q.size() > 0) begin
            run_to(gs + GATE - 10);
            gs = gs + PERIOD;
            plan_gate(gs, plan_q.pop_front(), 1'b1);
        end
    endtask

    always @(negedge refclk) begin
        if (count_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_pulse at cycle %0d: actual count_valid=1 freq_count=%0d, required no pulse",
                         cyc, freq_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("freq_count", freq_count, mon_e.cnt);
                check("overflow", overflow, mon_e.ovf);
            end
        end
    end

    initial begin
        cyc        = 0;
        n_checks   = 0;
        n_errs     = 0;
        last_cnt   = 0;
        rst        = 1'b1;
        meas_in    = 1'b0;
        pll_locked = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset_freq_count", freq_count, 0);
        check("reset_count_valid", count_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (5) tick();
        check("idle_busy", busy, 0);

        // Lock rises after posedge t: busy at t+3, first result at t+3+GATE
        pll_locked = 1'b1;
        t = cyc;
        s = t + 3;
        plan_gate(s, 10, 1'b1);
        run_to(t + 2);
        check("busy_before_lock_path", busy, 0);
        tick();
        check("busy_after_lock_path", busy, 1);

        // Period 3 overflows an 8-bit count, then random periods, then 10 again
        plan_q.push_back(3);
        for (int k = 0; k < 4; k++) plan_q.push_back(int'($urandom_range(40, 3)));
        plan_q.push_back(10);
        run_chain(s);

        // Lock lost at gate cycle 500: no result, previous value held
        run_to(s + GATE - 10);
        s = s + PERIOD;
        plan_gate(s, int'($urandom_range(40, 3)), 1'b0);
        run_to(s + 498);
        pll_locked = 1'b0;
        run_to(s + 500);
        check("busy_before_abort", busy, 1);
        tick();
        check("busy_after_abort", busy, 0);
        check("freq_count_kept_after_abort", freq_count, last_cnt);

        // Relock with meas_in held high across the whole window: count 0
        fill(cyc + 1, cyc + 1200, 0);
        repeat (20) tick();
        check("idle_busy_after_abort", busy, 0);
        pll_locked = 1'b1;
        t = cyc;
        s = t + 3;
        plan_gate(s, 0, 1'b1);

        // Reset pulse at gate cycle 300 of the next window
        run_to(s + GATE - 10);
        s = s + PERIOD;
        plan_gate(s, 10, 1'b0);
        run_to(s + 300);
        rst = 1'b1;
        plan_gate(s + 304, 10, 1'b1);   // reset at posedge s+301, lock path restarts 3 cycles later
        tick();
        rst = 1'b0;
        check("midgate_reset_freq_count", freq_count, 0);
        check("midgate_reset_count_valid", count_valid, 0);
        check("midgate_reset_overflow", overflow, 0);
        check("midgate_reset_busy", busy, 0);
        s = s + 304;
        for (int k = 0; k < 2; k++) plan_q.push_back(int'($urandom_range(40, 3)));
        run_chain(s);
        run_to(s + GATE + 5);

        check("pending_pulses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
